// File: rtl/unary_arb_pkg.sv
// Shared definitions for the unary/reduction operator arbiter: op codes, op field
// width and FSM state encoding.
package unary_arb_pkg;

  localparam int unsigned OpW = 3;

  localparam logic [OpW-1:0] OP_NOT  = 3'd0;
  localparam logic [OpW-1:0] OP_AND  = 3'd1;
  localparam logic [OpW-1:0] OP_NAND = 3'd2;
  localparam logic [OpW-1:0] OP_OR   = 3'd3;
  localparam logic [OpW-1:0] OP_NOR  = 3'd4;
  localparam logic [OpW-1:0] OP_XOR  = 3'd5;
  localparam logic [OpW-1:0] OP_XNOR = 3'd6;
  localparam logic [OpW-1:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } arb_state_e;

  function automatic logic op_is_rsvd(logic [OpW-1:0] op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping
// at N-1 -> 0. Produces a one-hot grant and the winner index.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(N);

  always_comb begin
    logic        found;
    int unsigned cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // k = N lands back on ptr itself, so a lone requester is always regranted
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && req[cand[IdxW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IdxW-1:0]]  = 1'b1;
        idx                  = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/unary_op_arbiter.sv
// Shares one registered unary/reduction unit between N round-robin requesters.
// Optional handshake counter port stat_count when UNARY_ARB_STATS_EN is defined.
module unary_op_arbiter
  import unary_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [3*N-1:0]       req_op,
  input  logic [W*N-1:0]       req_data,
  output logic [N-1:0]         gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_result,
  output logic [$clog2(N)-1:0] out_id,
  output logic                 out_err,
`ifdef UNARY_ARB_STATS_EN
  output logic [15:0]          stat_count,
`endif
  output logic                 busy
);

  localparam int unsigned IdxW = $clog2(N);

  arb_state_e state_q, state_d;

  logic [IdxW-1:0] ptr_q;
  logic [N-1:0]    arb_gnt;
  logic [IdxW-1:0] arb_idx;
  logic            grant_en;

  logic [OpW-1:0]  op_q;
  logic [W-1:0]    data_q;
  logic [IdxW-1:0] id_q;

  logic [W-1:0]    result_q;
  logic            err_q;
  logic [IdxW-1:0] out_id_q;
  logic            valid_q;

  rr_arbiter #(
    .N(N)
  ) u_rr_arbiter (
    .req(req),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  function automatic logic [W-1:0] reduce_op(logic [OpW-1:0] op, logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    case (op)
      OP_NOT:  r    = ~d;
      OP_AND:  r[0] = &d;
      OP_NAND: r[0] = ~&d;
      OP_OR:   r[0] = |d;
      OP_NOR:  r[0] = ~|d;
      OP_XOR:  r[0] = ^d;
      OP_XNOR: r[0] = ~^d;
      default: r    = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|req) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant is only offered from IDLE; pending requests simply wait otherwise.
  always_comb begin
    gnt      = '0;
    grant_en = 1'b0;
    busy     = (state_q != StIdle);
    if (state_q == StIdle && !rst) begin
      gnt      = arb_gnt;
      grant_en = |req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= IdxW'(N - 1);
      op_q     <= '0;
      data_q   <= '0;
      id_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      out_id_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (grant_en) begin
        ptr_q  <= arb_idx;
        op_q   <= req_op[OpW*arb_idx +: OpW];
        data_q <= req_data[W*arb_idx +: W];
        id_q   <= arb_idx;
      end
      if (state_q == StExec) begin
        result_q <= reduce_op(op_q, data_q);
        err_q    <= op_is_rsvd(op_q);
        out_id_q <= id_q;
        valid_q  <= 1'b1;
      end else if (state_q == StDone && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_id     = out_id_q;
  assign out_err    = err_q;

`ifdef UNARY_ARB_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (valid_q && out_ready && stat_q != 16'hFFFF) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_unary_op_arbiter.sv
// Self-checking bench for unary_op_arbiter (N=4, W=8) with a behavioural model of
// the round-robin order and the reduction ops; define UNARY_ARB_STATS_EN to cover stat_count.
module tb_unary_op_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic [1:0]     out_id;
  logic           out_err;
  logic           busy;
  logic [15:0]    stat_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ptr;

  unary_op_arbiter #(
    .N(N),
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_op(req_op),
    .req_data(req_data),
    .gnt(gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_id(out_id),
    .out_err(out_err),
`ifdef UNARY_ARB_STATS_EN
    .stat_count(stat_count),
`endif
    .busy(busy)
  );

`ifndef UNARY_ARB_STATS_EN
  assign stat_count = 16'h0;
`endif

  always #5 clk = ~clk;

  // Model: next requester after the last winner, wrapping around.
  function automatic int model_winner(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Model: results from the op definitions using plain arithmetic.
  function automatic logic [W-1:0] ref_result(input int op, input logic [W-1:0] d);
    int ones;
    ones = $countones(d);
    case (op)
      0: return ~d;
      1: return (d == 8'hFF) ? 8'h01 : 8'h00;
      2: return (d == 8'hFF) ? 8'h00 : 8'h01;
      3: return (d != 0) ? 8'h01 : 8'h00;
      4: return (d == 0) ? 8'h01 : 8'h00;
      5: return W'(ones % 2);
      6: return W'(1 - ones % 2);
      default: return 8'h00;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_ptr = N - 1;
  endtask

  // Runs one request round: waits for a grant, drops the granted bit, waits for the
  // result, stalls 'hold' cycles with out_ready low, then accepts.
  task automatic transact(input logic [N-1:0] rq, input int hold, output logic [N-1:0] g,
                          output logic [W-1:0] res, output logic [1:0] id, output logic err,
                          output int lat, output bit hold_ok);
    hold_ok   = 1'b1;
    g         = '0;
    out_ready = 1'b0;
    req       = rq;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        g = gnt;
        break;
      end
    end
    @(posedge clk); #1 req = rq & ~g;
    lat = 99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    res = out_result;
    id  = out_id;
    err = out_err;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (!out_valid || !busy || gnt != 0 || out_result !== res || out_id !== id ||
          out_err !== err) hold_ok = 1'b0;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_op = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (out_result !== 8'h00) begin n_bad++; $display("FAIL reset_result got %h want 00", out_result); end
    n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL reset_id got %0d want 0", out_id); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", out_err); end
    @(posedge clk); #1 rst = 1'b0;
    exp_ptr = N - 1;
  endtask

  task automatic test_ops();
    logic [2:0] ops [4] = '{3'd5, 3'd0, 3'd2, 3'd4};
    logic [7:0] dat [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [7:0] exp [4] = '{8'h00, 8'hC3, 8'h00, 8'h01};
    logic [N-1:0] g; logic [W-1:0] res; logic [1:0] id; logic err; int lat; bit ok;
    for (int i = 0; i < 4; i++) begin
      req_op = '0; req_data = '0;
      req_op[5:3] = ops[i]; req_data[15:8] = dat[i];
      transact(4'b0010, 0, g, res, id, err, lat, ok);
      n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("FAIL ops_gnt[%0d] got %b want 0010", i, g); end
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL ops_latency[%0d] got %0d want 2", i, lat); end
      n_cmp++; if (res !== exp[i]) begin n_bad++; $display("FAIL ops_result[%0d] got %h want %h", i, res, exp[i]); end
      n_cmp++; if (id !== 2'd1) begin n_bad++; $display("FAIL ops_id[%0d] got %0d want 1", i, id); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ops_err[%0d] got %b want 0", i, err); end
    end
    exp_ptr = 1;
  endtask

  task automatic test_round_robin();
    int widx [5]; int wcyc [5]; int ng; int w;
    do_reset();
    ng = 0;
    req = 4'b1111; out_ready = 1'b1; req_op = '0; req_data = 32'h1234_5678;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        widx[ng] = -1;
        for (int b = 0; b < N; b++) if (gnt == 4'(1 << b)) widx[ng] = b;
        wcyc[ng] = c;
        ng++;
      end
    end
    @(posedge clk); #1 req = '0;
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if (ng != 5) begin n_bad++; $display("FAIL rr_count got %0d want 5", ng); end
    w = exp_ptr;
    for (int k = 0; k < ng; k++) begin
      w = model_winner(4'b1111, w);
      n_cmp++; if (widx[k] != w) begin n_bad++; $display("FAIL rr_order[%0d] got %0d want %0d", k, widx[k], w); end
      if (k > 0) begin
        n_cmp++; if (wcyc[k] - wcyc[k-1] != 3) begin
          n_bad++; $display("FAIL rr_spacing[%0d] got %0d want 3", k, wcyc[k] - wcyc[k-1]);
        end
      end
    end
    exp_ptr = w;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g; logic [W-1:0] res; logic [1:0] id; logic err; int lat; bit ok;
    logic [N-1:0] pend; int w;
    req_op = '0; req_data = '0;
    req_op[2:0] = 3'd3; req_data[7:0]  = 8'h10;
    req_op[5:3] = 3'd6; req_data[15:8] = 8'h07;
    pend = 4'b0011;
    for (int t = 0; t < 2; t++) begin
      w = model_winner(pend, exp_ptr);
      transact(pend, (t == 0) ? 5 : 0, g, res, id, err, lat, ok);
      n_cmp++; if (g !== 4'(1 << w)) begin n_bad++; $display("FAIL bp_gnt[%0d] got %b want %b", t, g, 4'(1 << w)); end
      n_cmp++; if (res !== ref_result(int'(req_op[3*w +: 3]), req_data[8*w +: 8])) begin
        n_bad++; $display("FAIL bp_result[%0d] got %h want %h", t, res,
                          ref_result(int'(req_op[3*w +: 3]), req_data[8*w +: 8]));
      end
      n_cmp++; if (int'(id) != w) begin n_bad++; $display("FAIL bp_id[%0d] got %0d want %0d", t, id, w); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold_stable[%0d] got %b want 1", t, ok); end
      pend[w] = 1'b0;
      exp_ptr = w;
    end
  endtask

  task automatic test_reserved();
    logic [N-1:0] g; logic [W-1:0] res; logic [1:0] id; logic err; int lat; bit ok;
    req_op = '0; req_data = '0;
    req_op[8:6] = 3'd7; req_data[23:16] = 8'hFF;
    transact(4'b0100, 0, g, res, id, err, lat, ok);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rsvd_err got %b want 1", err); end
    n_cmp++; if (res !== 8'h00) begin n_bad++; $display("FAIL rsvd_result got %h want 00", res); end
    req_op[8:6] = 3'd1;
    transact(4'b0100, 0, g, res, id, err, lat, ok);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL after_rsvd_err got %b want 0", err); end
    n_cmp++; if (res !== 8'h01) begin n_bad++; $display("FAIL after_rsvd_result got %h want 01", res); end
    n_cmp++; if (id !== 2'd2) begin n_bad++; $display("FAIL after_rsvd_id got %0d want 2", id); end
    exp_ptr = 2;
  endtask

  task automatic test_random();
    logic [N-1:0] g; logic [W-1:0] res; logic [1:0] id; logic err; int lat; bit ok;
    logic [N-1:0] pend; logic [W-1:0] er; int w; int op; int hold;
    pend = '0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) pend = pend & 4'($urandom_range(0, 15));
      pend = pend | 4'($urandom_range(0, 15));
      if (pend == 0) pend = 4'(1 << $urandom_range(0, N - 1));
      req_op   = 12'($urandom);
      req_data = $urandom;
      hold     = $urandom_range(0, 3);
      w  = model_winner(pend, exp_ptr);
      op = int'(req_op[3*w +: 3]);
      er = ref_result(op, req_data[8*w +: 8]);
      transact(pend, hold, g, res, id, err, lat, ok);
      n_cmp++; if (g !== 4'(1 << w)) begin n_bad++; $display("FAIL rnd_gnt[%0d] got %b want %b", it, g, 4'(1 << w)); end
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL rnd_latency[%0d] got %0d want 2", it, lat); end
      n_cmp++; if (res !== er) begin n_bad++; $display("FAIL rnd_result[%0d] op %0d got %h want %h", it, op, res, er); end
      n_cmp++; if (int'(id) != w) begin n_bad++; $display("FAIL rnd_id[%0d] got %0d want %0d", it, id, w); end
      n_cmp++; if (err !== (op == 7)) begin n_bad++; $display("FAIL rnd_err[%0d] got %b want %b", it, err, op == 7); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd_hold_stable[%0d] got %b want 1", it, ok); end
      pend[w] = 1'b0;
      exp_ptr = w;
    end
    req = '0;
  endtask

  task automatic test_reset_midtx();
    logic [N-1:0] g;
    g = '0;
    req_op = '0; req_data = '1;
    @(posedge clk); #1 req = 4'b0100; out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        g = gnt;
        break;
      end
    end
    n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL midrst_gnt got %b want 0100", g); end
    @(posedge clk); #1 rst = 1'b1; req = '0;
    @(posedge clk); #1 rst = 1'b0;
    exp_ptr = N - 1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (out_result !== 8'h00) begin n_bad++; $display("FAIL midrst_result got %h want 00", out_result); end
    @(posedge clk); #1 req = 4'b1111;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'(1 << model_winner(4'b1111, exp_ptr))) begin
      n_bad++; $display("FAIL midrst_next_gnt got %b want %b", gnt, 4'(1 << model_winner(4'b1111, exp_ptr)));
    end
    @(posedge clk); #1 req = '0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    exp_ptr = 0;
  endtask

`ifdef UNARY_ARB_STATS_EN
  task automatic test_stats();
    logic [N-1:0] g; logic [W-1:0] res; logic [1:0] id; logic err; int lat; bit ok;
    do_reset();
    @(negedge clk);
    n_cmp++; if (stat_count !== 16'd0) begin n_bad++; $display("FAIL stats_after_reset got %0d want 0", stat_count); end
    for (int i = 0; i < 3; i++) transact(4'b0001, i, g, res, id, err, lat, ok);
    @(negedge clk);
    n_cmp++; if (stat_count !== 16'd3) begin n_bad++; $display("FAIL stats_count got %0d want 3", stat_count); end
    do_reset();
    @(negedge clk);
    n_cmp++; if (stat_count !== 16'd0) begin n_bad++; $display("FAIL stats_clear got %0d want 0", stat_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_reserved();
    test_random();
    test_reset_midtx();
`ifdef UNARY_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
